// File: rtl/l2_mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : l2_mem_arbiter_pkg                                            |
// | Description : Shared types for the L1-to-L2 line arbiter.                   |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package l2_mem_arbiter_pkg;

   localparam int LC3B_WORD_W    = 16;
   localparam int LC3B_L1_LINE_W = 128;

   typedef logic [LC3B_WORD_W-1:0]    lc3b_word;
   typedef logic [LC3B_L1_LINE_W-1:0] lc3b_L1_line;

   typedef enum logic [2:0] {
      ARB_IDLE    = 3'd0,
      ARB_INST    = 3'd1,
      ARB_DATA_RD = 3'd2,
      ARB_DATA_WR = 3'd3,
      ARB_TURN    = 3'd4
   } lc3b_arb_state;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } lc3b_arb_owner;

   function automatic lc3b_arb_owner other_owner(input lc3b_arb_owner o);
      return (o == OWN_INST) ? OWN_DATA : OWN_INST;
   endfunction

endpackage
`default_nettype wire

// File: rtl/l2_mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : l2_mem_arbiter_if                                             |
// | Description : L1 request / L2 command bundle seen by the arbiter.           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface l2_mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
);
   logic              inst_rd_req;
   logic [ADDR_W-1:0] inst_address;
   logic              data_rd_req;
   logic              data_wr_req;
   logic [ADDR_W-1:0] data_address;
   logic [LINE_W-1:0] data_wdata;
   logic              L2_resp;
   logic              L2_read;
   logic              L2_write;
   logic [ADDR_W-1:0] L2_address;
   logic [LINE_W-1:0] L2_wdata;
   logic              arb_inst_resp;
   logic              arb_data_resp;
   logic              busy;

   // Arbiter side
   modport master (
      input  inst_rd_req, inst_address, data_rd_req, data_wr_req,
             data_address, data_wdata, L2_resp,
      output L2_read, L2_write, L2_address, L2_wdata,
             arb_inst_resp, arb_data_resp, busy
   );

   // Cache / memory side
   modport slave (
      output inst_rd_req, inst_address, data_rd_req, data_wr_req,
             data_address, data_wdata, L2_resp,
      input  L2_read, L2_write, L2_address, L2_wdata,
             arb_inst_resp, arb_data_resp, busy
   );
endinterface
`default_nettype wire

// File: rtl/l2_mem_arbiter_rr_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arb_rr_select                                                 |
// | Description : Two-way round-robin pick between icache and dcache.           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module arb_rr_select
   import l2_mem_arbiter_pkg::*;
(
   input  wire logic    inst_req,
   input  wire logic    data_req,
   input  lc3b_arb_owner last_owner,
   output logic          grant_valid,
   output lc3b_arb_owner grant_owner
);

   always_comb begin
      grant_valid = inst_req | data_req;
      grant_owner = OWN_INST;
      // On a tie the side that did not win last time goes next
      if (inst_req && data_req) begin
         grant_owner = other_owner(last_owner);
      end else if (data_req) begin
         grant_owner = OWN_DATA;
      end
   end

endmodule
`default_nettype wire

// File: rtl/l2_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : l2_mem_arbiter                                                |
// | Description : Shares one L2 port between icache and dcache, one line at a   |
// |               time, round-robin on contention.                              |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module l2_mem_arbiter
   import l2_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = LC3B_WORD_W,
   parameter int LINE_W = LC3B_L1_LINE_W
) (
   input wire logic          clk,
   input wire logic          rst,
   l2_mem_arbiter_if.master  bus
);

   lc3b_arb_state     state_q,      state_d;
   lc3b_arb_owner     last_owner_q, last_owner_d;
   logic [ADDR_W-1:0] addr_q,       addr_d;
   logic [LINE_W-1:0] wdata_q,      wdata_d;

   logic              w_data_req;
   logic              w_grant_valid;
   lc3b_arb_owner     w_grant_owner;
   logic              w_owned;

   assign w_data_req = bus.data_rd_req | bus.data_wr_req;

   arb_rr_select u_rr_select (
      .inst_req    (bus.inst_rd_req),
      .data_req    (w_data_req),
      .last_owner  (last_owner_q),
      .grant_valid (w_grant_valid),
      .grant_owner (w_grant_owner)
   );

   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      case (state_q)
         ARB_IDLE: begin
            if (w_grant_valid) begin
               last_owner_d = w_grant_owner;
               if (w_grant_owner == OWN_INST) begin
                  state_d = ARB_INST;
                  addr_d  = bus.inst_address;
               end else begin
                  addr_d = bus.data_address;
                  // Writeback goes out before the fill of the same miss
                  if (bus.data_wr_req) begin
                     state_d = ARB_DATA_WR;
                     wdata_d = bus.data_wdata;
                  end else begin
                     state_d = ARB_DATA_RD;
                  end
               end
            end
         end
         ARB_INST, ARB_DATA_RD, ARB_DATA_WR: begin
            if (bus.L2_resp) begin
               state_d = ARB_TURN;
            end
         end
         ARB_TURN: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         last_owner_q <= OWN_DATA;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
      end
   end

   assign w_owned = (state_q == ARB_INST) || (state_q == ARB_DATA_RD) ||
                    (state_q == ARB_DATA_WR);

   assign bus.L2_read       = (state_q == ARB_INST) || (state_q == ARB_DATA_RD);
   assign bus.L2_write      = (state_q == ARB_DATA_WR);
   assign bus.L2_address    = addr_q;
   assign bus.L2_wdata      = wdata_q;
   // Completion is forwarded in the same cycle L2 signals it, and only to the owner
   assign bus.arb_inst_resp = bus.L2_resp && (state_q == ARB_INST);
   assign bus.arb_data_resp = bus.L2_resp && w_owned && (state_q != ARB_INST);
   assign bus.busy          = (state_q != ARB_IDLE);

endmodule
`default_nettype wire
